// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// instr_fetch_unit : PC holder and single-outstanding instruction fetcher
// Rev 1.0
// ============================================================================
module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [31:0]      instr,
  output logic [XLEN-1:0]  instr_pc,
  output logic [6:0]       opcode,
  output logic [2:0]       funct3,
  output logic [6:0]       funct7,
  input  logic             selBranch,
  input  logic             jump,
  input  logic [XLEN-1:0]  branch_target,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [XLEN-1:0]  pc;
  logic [31:0]      instr_q;
  logic [XLEN-1:0]  instr_pc_q;
  logic [CNT_W-1:0] count_q;

  logic             load;
  logic             handoff;
  logic [XLEN-1:0]  target_aligned;
  logic [XLEN-1:0]  pc_next;

  assign load           = (state == WAIT) && imem_rvalid;
  assign handoff        = (state == HOLD) && instr_ready;
  assign target_aligned = branch_target & ~{{(XLEN-2){1'b0}}, 2'b11};
  assign pc_next        = (selBranch | jump) ? target_aligned : pc + XLEN'(4);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      instr_q    <= NOP;
      instr_pc_q <= RESET_PC;
      count_q    <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        instr_q    <= imem_rdata;
        instr_pc_q <= pc;
      end
      if (handoff) begin
        pc      <= pc_next;
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH:   if (imem_gnt)    state_next = WAIT;
      WAIT:    if (imem_rvalid) state_next = HOLD;
      HOLD:    if (instr_ready) state_next = FETCH;
      default:                  state_next = FETCH;
    endcase
  end

  // Request is masked during reset so nothing is issued in the reset cycle itself.
  always_comb begin
    imem_req    = (state == FETCH) && !reset;
    imem_addr   = pc;
    instr_valid = (state == HOLD);
  end

  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign opcode      = instr_q[6:0];
  assign funct3      = instr_q[14:12];
  assign funct7      = instr_q[31:25];
  assign fetch_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_instr_fetch_unit : directed + randomized bench with a transaction model
// Rev 1.0
// ============================================================================
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        sel_branch = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] fetch_count;

  int vectors = 0;
  int miscompares = 0;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .selBranch(sel_branch), .jump(jump), .branch_target(branch_target),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Transaction-level model: a fetch is either being requested, outstanding
  // (granted, awaiting data) or delivered (held until consumed).
  logic [31:0] m_pc = 32'h0;
  logic        m_held = 1'b0;
  logic        m_out = 1'b0;
  logic [31:0] m_instr = 32'h13;
  logic [31:0] m_ipc = 32'h0;
  logic [31:0] m_count = 32'h0;

  always @(posedge clk) begin
    if (reset) begin
      m_pc = 32'h0; m_held = 1'b0; m_out = 1'b0;
      m_instr = 32'h13; m_ipc = 32'h0; m_count = 32'h0;
    end else if (m_held) begin
      if (instr_ready) begin
        m_count = m_count + 1;
        m_pc = (sel_branch || jump) ? (branch_target & 32'hFFFF_FFFC) : m_pc + 32'd4;
        m_held = 1'b0;
      end
    end else if (m_out) begin
      if (imem_rvalid) begin
        m_instr = imem_rdata; m_ipc = m_pc; m_held = 1'b1; m_out = 1'b0;
      end
    end else if (imem_gnt) begin
      m_out = 1'b1;
    end
  end

  always @(posedge clk) begin
    logic exp_req;
    #1;
    exp_req = !reset && !m_held && !m_out;
    chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_held});
    chk("instr", instr, m_instr);
    chk("instr_pc", instr_pc, m_ipc);
    chk("opcode", {25'b0, opcode}, {25'b0, m_instr[6:0]});
    chk("funct3", {29'b0, funct3}, {29'b0, m_instr[14:12]});
    chk("funct7", {25'b0, funct7}, {25'b0, m_instr[31:25]});
    chk("fetch_count", fetch_count, m_count);
  end

  // Entered and left on a falling edge with the DUT requesting.
  task automatic do_fetch(input logic [31:0] exp_addr, input int gnt_wait,
                          input logic [31:0] data, input int stall,
                          input logic sb, input logic jp, input logic [31:0] tgt);
    logic [31:0] cnt0;
    chk("fetch_addr", imem_addr, exp_addr);
    for (int i = 0; i < gnt_wait; i++) begin
      imem_gnt = 1'b0;
      @(negedge clk);
      chk("nognt_req", {31'b0, imem_req}, 32'd1);
      chk("nognt_addr", imem_addr, exp_addr);
    end
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = data;
    @(negedge clk);
    imem_rvalid = 1'b0; instr_ready = 1'b0;
    cnt0 = fetch_count;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_instr", instr, data);
      chk("stall_pc", instr_pc, exp_addr);
      chk("stall_req", {31'b0, imem_req}, 32'd0);
      chk("stall_cnt", fetch_count, cnt0);
    end
    instr_ready = 1'b1; sel_branch = sb; jump = jp; branch_target = tgt;
    @(negedge clk);
    instr_ready = 1'b0; sel_branch = 1'b0; jump = 1'b0;
  endtask

  initial begin
    logic        pending;
    int          delay;
    logic        req_now;

    repeat (2) @(negedge clk);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_count", fetch_count, 32'd0);
    reset = 1'b0;

    // First fetch, checked by hand.
    @(negedge clk);
    chk("f1_req", {31'b0, imem_req}, 32'd1);
    chk("f1_addr", imem_addr, 32'h0);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093; instr_ready = 1'b1;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("f1_valid", {31'b0, instr_valid}, 32'd1);
    chk("f1_opcode", {25'b0, opcode}, 32'h13);
    chk("f1_funct3", {29'b0, funct3}, 32'h0);
    chk("f1_funct7", {25'b0, funct7}, 32'h0);
    chk("f1_ipc", instr_pc, 32'h0);
    @(negedge clk);
    instr_ready = 1'b0;
    chk("f1_next_addr", imem_addr, 32'h4);
    chk("f1_count", fetch_count, 32'd1);

    do_fetch(32'h4,   0, 32'h0020_8133, 5, 1'b0, 1'b0, 32'h0);
    do_fetch(32'h8,   0, 32'h0031_0463, 0, 1'b1, 1'b0, 32'h103);
    chk("br_addr", imem_addr, 32'h100);
    do_fetch(32'h100, 0, 32'h0400_006F, 0, 1'b0, 1'b1, 32'h40);
    chk("jmp_addr", imem_addr, 32'h40);
    do_fetch(32'h40,  0, 32'h4020_8233, 0, 1'b0, 1'b0, 32'h80);
    chk("seq_addr", imem_addr, 32'h44);
    do_fetch(32'h44,  4, 32'h0000_0013, 0, 1'b0, 1'b0, 32'h0);
    chk("gntwait_next", imem_addr, 32'h48);
    chk("count6", fetch_count, 32'd6);

    // Reset while a request is outstanding; the late response must be dropped.
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("rw_req_in_reset", {31'b0, imem_req}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rw_req", {31'b0, imem_req}, 32'd1);
    chk("rw_addr", imem_addr, 32'h0);
    chk("rw_count", fetch_count, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("rw_valid", {31'b0, instr_valid}, 32'd0);
    chk("rw_instr", instr, 32'h0000_0013);
    chk("rw_req2", {31'b0, imem_req}, 32'd1);
    chk("rw_addr2", imem_addr, 32'h0);

    // PC wrap-around.
    do_fetch(32'h0, 0, 32'h0000_006F, 0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    chk("wrap_pre", imem_addr, 32'hFFFF_FFFC);
    do_fetch(32'hFFFF_FFFC, 0, 32'h0000_0013, 2, 1'b0, 1'b0, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_count", fetch_count, 32'd2);

    // Randomized phase with a memory that grants and responds with random delay.
    pending = 1'b0;
    delay = 0;
    for (int c = 0; c < 4000; c++) begin
      req_now = imem_req;
      reset = ($urandom_range(0, 249) == 0);
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      if (pending) begin
        if (delay == 0) begin
          imem_rvalid = 1'b1; imem_rdata = $urandom; pending = 1'b0;
        end else begin
          delay--;
        end
      end else if (!m_out && $urandom_range(0, 9) == 0) begin
        imem_rvalid = 1'b1; imem_rdata = $urandom;
      end
      if (req_now && !pending && $urandom_range(0, 1) == 1) begin
        imem_gnt = 1'b1; pending = 1'b1; delay = $urandom_range(0, 2);
      end else if (!req_now && $urandom_range(0, 9) == 0) begin
        imem_gnt = 1'b1;
      end
      instr_ready = $urandom_range(0, 1) == 1;
      sel_branch = $urandom_range(0, 3) == 0;
      jump = $urandom_range(0, 3) == 0;
      branch_target = $urandom;
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
